// File: rtl/m_cpu_pkg.sv
// m_cpu_pkg: shared fetch FSM state type, PC step and opcode-field geometry.
package m_cpu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} fetchState_t;
    localparam int PC_STEP = 4;
    localparam int OPT_W   = 3;
    localparam int OPT_LSB = 0;
    localparam int OPT_MSB = OPT_LSB + OPT_W - 1;
endpackage

// File: rtl/m_fetch_unit_if.sv
// m_fetch_unit_if: instruction-memory read bus plus instruction offer/accept handshake.
interface m_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic                        imem_req;
    logic [ADDR_W-1:0]           imem_addr;
    logic                        imem_ack;
    logic [INSTR_W-1:0]          imem_rdata;
    logic                        instr_valid;
    logic [INSTR_W-1:0]          instr;
    logic [m_cpu_pkg::OPT_W-1:0] opt;
    logic                        instr_ready;
    logic                        br;
    logic [ADDR_W-1:0]           br_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opt,
        input  imem_ack, imem_rdata, instr_ready, br, br_target
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opt,
        output imem_ack, imem_rdata, instr_ready, br, br_target
    );
endinterface

// File: rtl/m_fetch_unit.sv
// m_fetch_unit: IDLE/REQ/HOLD fetch FSM feeding one instruction at a time to the controller.
// Define M_FETCH_PERF_EN to add the perf_fetch_cnt handshake counter port.
module m_fetch_unit
    import m_cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    m_fetch_unit_if.master  bus
`ifdef M_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt
`endif
);
    fetchState_t       state;
    logic [ADDR_W-1:0] pc;
    logic              handshake;

    assign handshake     = bus.instr_valid & bus.instr_ready;
    assign bus.imem_addr = pc;
    assign bus.opt       = bus.instr[OPT_MSB:OPT_LSB];

    // Outputs are registered alongside the state so imem_req and instr_valid are never both high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.instr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= REQ;
                    bus.imem_req <= 1'b1;
                end
                REQ: if (bus.imem_ack) begin
                    state           <= HOLD;
                    bus.instr       <= bus.imem_rdata;
                    bus.imem_req    <= 1'b0;
                    bus.instr_valid <= 1'b1;
                end
                HOLD: if (handshake) begin
                    state           <= REQ;
                    pc              <= bus.br ? (bus.br_target & ~ADDR_W'(3)) : pc + ADDR_W'(PC_STEP);
                    bus.imem_req    <= 1'b1;
                    bus.instr_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef M_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_fetch_cnt <= '0;
        else if (handshake) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_m_fetch_unit.sv
// tb_m_fetch_unit: directed and random stimulus against a transaction-level fetch model.
module tb_m_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nCompared = 0;
    int   nMismatched = 0;

    m_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
    m_fetch_unit_if #(.ADDR_W(8),  .INSTR_W(32)) sBus ();

`ifdef M_FETCH_PERF_EN
    logic [31:0] perfCnt;
    logic [31:0] sPerfCnt;
`endif

    m_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef M_FETCH_PERF_EN
        , .perf_fetch_cnt(perfCnt)
`endif
    );

    m_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hFC)) smallDut (
        .clk(clk), .rst_n(rst_n), .bus(sBus)
`ifdef M_FETCH_PERF_EN
        , .perf_fetch_cnt(sPerfCnt)
`endif
    );

    assign sBus.imem_ack    = 1'b1;
    assign sBus.instr_ready = 1'b1;
    assign sBus.br          = 1'b0;
    assign sBus.br_target   = 8'h00;
    assign sBus.imem_rdata  = 32'h0;

    always #5 clk = ~clk;

    // Model: a fetch is either outstanding (waiting for ack) or offered (waiting for ready).
    bit          started;
    bit          offering;
    logic [31:0] pcExp;
    logic [31:0] instrExp;
    int          fetches;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        started = 0; offering = 0; pcExp = 32'h0; instrExp = 32'h0; fetches = 0;
    endtask

    task automatic compareAll();
        check("imem_req", 64'(bus.imem_req), 64'(started && !offering));
        check("instr_valid", 64'(bus.instr_valid), 64'(offering));
        check("imem_addr", 64'(bus.imem_addr), 64'(pcExp));
        check("instr", 64'(bus.instr), 64'(instrExp));
        check("opt", 64'(bus.opt), 64'(instrExp % 8));
`ifdef M_FETCH_PERF_EN
        check("perf_fetch_cnt", 64'(perfCnt), 64'(fetches));
`endif
    endtask

    task automatic cyc(input logic ack, input logic rdy, input logic brv, input logic [31:0] tgt);
        logic [31:0] rd;
        rd = $urandom;
        bus.imem_ack = ack; bus.instr_ready = rdy; bus.br = brv; bus.br_target = tgt; bus.imem_rdata = rd;
        if (!started) started = 1;
        else if (!offering) begin
            if (ack) begin offering = 1; instrExp = rd; end
        end else if (rdy) begin
            pcExp = brv ? {tgt[31:2], 2'b00} : pcExp + 32'd4;
            offering = 0;
            fetches++;
        end
        @(negedge clk);
        compareAll();
    endtask

    initial begin
        bus.imem_ack = 0; bus.instr_ready = 0; bus.br = 0; bus.br_target = 0; bus.imem_rdata = 0;
        modelReset();
        repeat (2) @(negedge clk);
        compareAll();
        check("small_addr_rst", 64'(sBus.imem_addr), 64'h00FC);
        rst_n = 1'b1;
        check("small_req_idle", 64'(sBus.imem_req), 64'h0);
        // Small 8-bit unit with ack/ready tied high: FC fetched, then PC wraps to 00.
        for (int i = 0; i < 3; i++) begin
            logic [7:0] addrTab [3];
            logic       reqTab [3];
            addrTab = '{8'hFC, 8'hFC, 8'h00};
            reqTab  = '{1'b1, 1'b0, 1'b1};
            cyc(1, 1, 0, 32'h0);
            check("small_addr", 64'(sBus.imem_addr), 64'(addrTab[i]));
            check("small_req", 64'(sBus.imem_req), 64'(reqTab[i]));
            check("small_valid", 64'(sBus.instr_valid), 64'(!reqTab[i]));
        end
        repeat (5) cyc(1, 1, 0, 32'h0);
        cyc(1, 0, 1, 32'h99);
        cyc(0, 0, 1, 32'h77);
        cyc(0, 1, 1, 32'h43);
        check("branch_addr", 64'(bus.imem_addr), 64'h40);
        repeat (3) cyc(0, 0, 1, 32'h11);
        cyc(1, 0, 0, 32'h0);
        repeat (5) cyc(1, 0, 1, 32'h22);
        cyc(0, 1, 0, 32'h0);
        check("seq_after_stall", 64'(bus.imem_addr), 64'h44);
        cyc(1, 0, 0, 32'h0);
        cyc(0, 1, 1, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        check("wrap_addr", 64'(bus.imem_addr), 64'h0);
        cyc(0, 0, 0, 32'h0);
        // Reset mid-REQ with ack held high: outputs clear at once, refetch from RESET_PC.
        bus.imem_ack = 1;
        #2 rst_n = 1'b0;
        #1 modelReset();
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_req", 64'(bus.imem_req), 64'h0);
        for (int i = 0; i < 2000; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                $urandom);
        rst_n = 1'b0;
        #1 modelReset();
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 21; i++) cyc(1, 1, 0, 32'h0);
`ifdef M_FETCH_PERF_EN
        check("perf_ten", 64'(perfCnt), 64'd10);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
